// File: rtl/midi_voice_allocator_if.sv
// Framed MIDI event handshake between the framer (master) and the voice allocator (slave).
interface midi_voice_allocator_if;
  logic       midi_event_valid;
  logic [7:0] midi_command;
  logic [6:0] midi_parameter_1;
  logic [6:0] midi_parameter_2;
  logic       midi_event_ack;

  modport master (
    output midi_event_valid,
    output midi_command,
    output midi_parameter_1,
    output midi_parameter_2,
    input  midi_event_ack
  );

  modport slave (
    input  midi_event_valid,
    input  midi_command,
    input  midi_parameter_1,
    input  midi_parameter_2,
    output midi_event_ack
  );
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: decodes note-on/off/all-notes-off events and drives
// per-voice gate, note and load strobe, stealing the least-recently-assigned voice when full.
module midi_voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned STEAL_GAP  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  midi_voice_allocator_if.slave   ev,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic                    busy
);
  localparam int unsigned NOTE_W = 7;
  localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned GAP_W  = (STEAL_GAP > 1) ? $clog2(STEAL_GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(STEAL_GAP - 1);
  localparam logic [6:0]       ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {IDLE, DECODE, SCAN, STEAL, ASSIGN, ACK, HOLDOFF} state_t;

  state_t             state;
  logic [3:0]         status_q;
  logic [NOTE_W-1:0]  p1_q;
  logic [6:0]         p2_q;
  logic               note_on_q;
  logic [NOTE_W-1:0]  note_q [NUM_VOICES];
  logic [IDX_W-1:0]   rank   [NUM_VOICES];
  logic [IDX_W-1:0]   scan_idx;
  logic               match_found, free_found;
  logic [IDX_W-1:0]   match_idx, free_idx, oldest_idx, target_q;
  logic [GAP_W-1:0]   gap_cnt;

  logic               cur_hit_c, match_any_c, free_any_c;
  logic [IDX_W-1:0]   match_sel_c, free_sel_c, oldest_sel_c, target_c;
  logic               channel_unused_c;

  // Channel nibble is a don't-care for voice scheduling.
  assign channel_unused_c = ^ev.midi_command[3:0];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
    assign voice_note[NOTE_W*v +: NOTE_W] = note_q[v];
  end

  // Fold the voice under the scan pointer into the running match/free/oldest results.
  always_comb begin
    cur_hit_c    = voice_gate[scan_idx] && (note_q[scan_idx] == p1_q);
    match_any_c  = match_found || cur_hit_c;
    match_sel_c  = match_found ? match_idx : scan_idx;
    free_any_c   = free_found || !voice_gate[scan_idx];
    free_sel_c   = free_found ? free_idx : scan_idx;
    oldest_sel_c = (rank[scan_idx] == '0) ? scan_idx : oldest_idx;
    target_c     = match_any_c ? match_sel_c : (free_any_c ? free_sel_c : oldest_sel_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ev.midi_event_ack <= 1'b0;
      voice_gate        <= '0;
      voice_load        <= '0;
      busy              <= 1'b0;
      status_q          <= '0;
      p1_q              <= '0;
      p2_q              <= '0;
      note_on_q         <= 1'b0;
      scan_idx          <= '0;
      match_found       <= 1'b0;
      free_found        <= 1'b0;
      match_idx         <= '0;
      free_idx          <= '0;
      oldest_idx        <= '0;
      target_q          <= '0;
      gap_cnt           <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        note_q[i] <= '0;
        rank[i]   <= IDX_W'(i);
      end
    end else begin
      ev.midi_event_ack <= 1'b0;
      voice_load        <= '0;
      case (state)
        IDLE: begin
          if (ev.midi_event_valid) begin
            status_q <= ev.midi_command[7:4];
            p1_q     <= ev.midi_parameter_1;
            p2_q     <= ev.midi_parameter_2;
            busy     <= 1'b1;
            state    <= DECODE;
          end
        end
        DECODE: begin
          scan_idx    <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          match_idx   <= '0;
          free_idx    <= '0;
          oldest_idx  <= '0;
          case (status_q)
            4'h9: begin
              note_on_q <= (p2_q != '0);
              state     <= SCAN;
            end
            4'h8: begin
              note_on_q <= 1'b0;
              state     <= SCAN;
            end
            4'hB: begin
              if (p1_q == ALL_NOTES_OFF) voice_gate <= '0;
              state <= ACK;
            end
            default: state <= ACK;
          endcase
        end
        SCAN: begin
          match_found <= match_any_c;
          match_idx   <= match_sel_c;
          free_found  <= free_any_c;
          free_idx    <= free_sel_c;
          oldest_idx  <= oldest_sel_c;
          scan_idx    <= scan_idx + IDX_W'(1);
          if (scan_idx == LAST_IDX) begin
            target_q <= target_c;
            if (!note_on_q) begin
              if (match_any_c) voice_gate[match_sel_c] <= 1'b0;
              state <= ACK;
            end else if (match_any_c || free_any_c) begin
              note_q[target_c]     <= p1_q;
              voice_gate[target_c] <= 1'b1;
              voice_load[target_c] <= 1'b1;
              state                <= ASSIGN;
            end else begin
              // Drop the stolen voice's gate so its envelope retriggers on reassignment.
              voice_gate[target_c] <= 1'b0;
              gap_cnt              <= '0;
              state                <= STEAL;
            end
          end
        end
        STEAL: begin
          if (gap_cnt == LAST_GAP) begin
            note_q[target_q]     <= p1_q;
            voice_gate[target_q] <= 1'b1;
            voice_load[target_q] <= 1'b1;
            state                <= ASSIGN;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ASSIGN: begin
          // Target becomes newest; voices younger than it shift down one place.
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (IDX_W'(i) == target_q) rank[i] <= LAST_IDX;
            else if (rank[i] > rank[target_q]) rank[i] <= rank[i] - IDX_W'(1);
          end
          state <= ACK;
        end
        ACK: begin
          ev.midi_event_ack <= 1'b1;
          state             <= HOLDOFF;
        end
        HOLDOFF: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
